// File: rtl/scb_pkg.sv
// Shared types and width helpers for the switched connection block.
package scb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_ERROR
  } cfg_state_t;

  function automatic int si_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int so_width(input int dout_words);
    return $clog2(dout_words + 1);
  endfunction

  function automatic int conf_width(input int din_words, input int lanes, input int dout_words);
    return din_words * si_width(lanes) + lanes * so_width(dout_words);
  endfunction

  function automatic int nch(input int conf_w, input int chunk_w);
    return (conf_w + chunk_w - 1) / chunk_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scb_cfg_loader.sv
// Configuration loader: chunk handshake FSM, beat counter and shadow register.
module scb_cfg_loader
  import scb_pkg::*;
#(
  parameter int CONF_WIDTH = 8,
  parameter int CW         = 4,
  parameter int NCH        = 2,
  parameter int CTXW       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CW-1:0]         cfg_data,
  input  logic                  cfg_last,
  input  logic [CTXW-1:0]       cfg_ctx,
  input  logic                  cfg_commit,
  input  logic                  cfg_abort,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  commit_en,
  output logic [CTXW-1:0]       commit_ctx,
  output logic [CONF_WIDTH-1:0] shadow
);

  localparam int CNTW = $clog2(NCH + 1);

  cfg_state_t      state, state_next;
  logic [CNTW-1:0] count;
  logic            accept;
  logic            last_beat;

  // Abort wins over a simultaneous beat, so the beat is simply not taken.
  assign accept    = cfg_valid && cfg_ready && !cfg_abort;
  assign last_beat = (count == CNTW'(NCH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (last_beat) state_next = cfg_last ? ST_ARMED : ST_ERROR;
          else           state_next = cfg_last ? ST_ERROR : ST_LOAD;
        end
      end
      ST_ARMED: if (cfg_commit) state_next = ST_IDLE;
      default:  state_next = state;
    endcase
    if (cfg_abort) state_next = ST_IDLE;
  end

  always_comb begin
    cfg_ready = (state == ST_IDLE) || (state == ST_LOAD);
    cfg_err   = (state == ST_ERROR);
    commit_en = (state == ST_ARMED) && cfg_commit && !cfg_abort;
  end

  // Chunks land LSB-first; bits beyond CONF_WIDTH in the final chunk are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      shadow     <= '0;
      commit_ctx <= '0;
      cfg_done   <= 1'b0;
    end else begin
      cfg_done <= commit_en;
      if (cfg_abort || commit_en) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNTW'(1);
        for (int b = 0; b < CONF_WIDTH; b++)
          if (count == CNTW'(b / CW)) shadow[b] <= cfg_data[b % CW];
        if (state == ST_IDLE) commit_ctx <= cfg_ctx;
      end
    end
  end

endmodule

// File: rtl/switched_connection_block.sv
// Context-switched crossbar between fabric tracks and MAC words.
// Define SCB_OUTPUT_REG_EN to register data_input/track_out (one cycle latency).
module switched_connection_block
  import scb_pkg::*;
#(
  parameter int W       = 16,
  parameter int WW      = 8,
  parameter int DATAIN  = 8,
  parameter int DATAOUT = 16,
  parameter int NCTX    = 2,
  parameter int CW      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 track_in,
  output logic [W-1:0]                 track_out,
  output logic [WW*DATAIN-1:0]         data_input,
  input  logic [WW*DATAOUT-1:0]        data_output,
  input  logic [idx_width(NCTX)-1:0]   ctx_sel,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CW-1:0]                cfg_data,
  input  logic                         cfg_last,
  input  logic [idx_width(NCTX)-1:0]   cfg_ctx,
  input  logic                         cfg_commit,
  input  logic                         cfg_abort,
  output logic                         cfg_done,
  output logic                         cfg_err
);

  localparam int L      = W / WW;
  localparam int SI     = si_width(L);
  localparam int SO     = so_width(DATAOUT);
  localparam int CONF_W = conf_width(DATAIN, L, DATAOUT);
  localparam int NCHK   = nch(CONF_W, CW);
  localparam int CTXW   = idx_width(NCTX);

  logic [CONF_W-1:0]   ctx_mem [NCTX];
  logic [CONF_W-1:0]   live;
  logic [CONF_W-1:0]   shadow;
  logic                commit_en;
  logic [CTXW-1:0]     commit_ctx;
  logic [WW*DATAIN-1:0] di_comb;
  logic [W-1:0]        to_comb;

  scb_cfg_loader #(
    .CONF_WIDTH(CONF_W),
    .CW        (CW),
    .NCH       (NCHK),
    .CTXW      (CTXW)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_ctx   (cfg_ctx),
    .cfg_commit(cfg_commit),
    .cfg_abort (cfg_abort),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .commit_en (commit_en),
    .commit_ctx(commit_ctx),
    .shadow    (shadow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCTX; c++) ctx_mem[c] <= '0;
    end else begin
      for (int c = 0; c < NCTX; c++)
        if (commit_en && commit_ctx == CTXW'(c)) ctx_mem[c] <= shadow;
    end
  end

  // Unpopulated context indices read as all-zero, i.e. plain pass-through.
  always_comb begin
    live = '0;
    for (int c = 0; c < NCTX; c++)
      if (ctx_sel == CTXW'(c)) live = ctx_mem[c];
  end

  always_comb begin
    di_comb = '0;
    for (int i = 0; i < DATAIN; i++)
      for (int j = 0; j < L; j++)
        if (live[i*SI +: SI] == SI'(j + 1)) di_comb[i*WW +: WW] = track_in[j*WW +: WW];
  end

  always_comb begin
    to_comb = '0;
    for (int k = 0; k < L; k++) begin
      if (live[DATAIN*SI + k*SO +: SO] == '0) to_comb[k*WW +: WW] = track_in[k*WW +: WW];
      for (int j = 0; j < DATAOUT; j++)
        if (live[DATAIN*SI + k*SO +: SO] == SO'(j + 1))
          to_comb[k*WW +: WW] = data_output[j*WW +: WW];
    end
  end

`ifdef SCB_OUTPUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_input <= '0;
      track_out  <= '0;
    end else begin
      data_input <= di_comb;
      track_out  <= to_comb;
    end
  end
`else
  assign data_input = di_comb;
  assign track_out  = to_comb;
`endif

endmodule
